// File: rtl/data_memory_lsu.sv
// Byte-addressed little-endian load/store data memory; responses are registered and arrive READ_LATENCY cycles after accept.
// Accepts one request per cycle (req_ready is low only during reset); there is no response backpressure.
module data_memory_lsu #(
  parameter int XLEN         = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_BYTES  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef struct packed {
    logic            vld;
    logic            err;
    logic [XLEN-1:0] dat;
  } stage_t;

  logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

  logic            ready_q;
  stage_t          pipe [READ_LATENCY];
  stage_t          new_stage;
  logic            accept;
  logic            size_err;
  logic            align_err;
  logic            range_err;
  logic            acc_err;
  logic [ADDR_WIDTH:0] last_addr;
  logic [AW-1:0]   idx0, idx1, idx2, idx3;
  logic [7:0]      b0, b1, b2, b3;
  logic [XLEN-1:0] load_dat;

  assign req_ready = ready_q;
  assign accept    = req_valid & ready_q & ~rst;

  // Bytes beyond the first wrap inside the array; that only matters for requests that error anyway.
  assign idx0 = req_addr[AW-1:0];
  assign idx1 = idx0 + AW'(1);
  assign idx2 = idx0 + AW'(2);
  assign idx3 = idx0 + AW'(3);
  assign b0   = mem[idx0];
  assign b1   = mem[idx1];
  assign b2   = mem[idx2];
  assign b3   = mem[idx3];

  always_comb begin
    last_addr = {1'b0, req_addr};
    size_err  = 1'b0;
    align_err = 1'b0;
    case (req_size)
      2'b00: ;
      2'b01: begin
        last_addr = {1'b0, req_addr} + (ADDR_WIDTH+1)'(1);
        align_err = req_addr[0];
      end
      2'b10: begin
        last_addr = {1'b0, req_addr} + (ADDR_WIDTH+1)'(3);
        align_err = |req_addr[1:0];
      end
      default: size_err = 1'b1;
    endcase
    range_err = (last_addr >= (ADDR_WIDTH+1)'(DEPTH_BYTES));
    acc_err   = size_err | align_err | range_err;
  end

  always_comb begin
    case (req_size)
      2'b00:   load_dat = {{(XLEN-8){~req_unsigned & b0[7]}}, b0};
      2'b01:   load_dat = {{(XLEN-16){~req_unsigned & b1[7]}}, b1, b0};
      default: load_dat = XLEN'({b3, b2, b1, b0});
    endcase
  end

  always_comb begin
    new_stage = '0;
    if (accept) begin
      new_stage.vld = 1'b1;
      new_stage.err = acc_err;
      new_stage.dat = (acc_err | req_we) ? '0 : load_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ready_q <= 1'b0;
    else     ready_q <= 1'b1;
  end

  // Array is deliberately outside reset so committed stores survive it.
  always_ff @(posedge clk) begin
    if (accept && req_we && !acc_err) begin
      mem[idx0] <= req_wdata[7:0];
      if (req_size != 2'b00) mem[idx1] <= req_wdata[15:8];
      if (req_size == 2'b10) begin
        mem[idx2] <= req_wdata[23:16];
        mem[idx3] <= req_wdata[31:24];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= new_stage;
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign resp_valid = pipe[READ_LATENCY-1].vld;
  assign resp_err   = pipe[READ_LATENCY-1].err;
  assign resp_rdata = pipe[READ_LATENCY-1].dat;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Scoreboard bench for data_memory_lsu at READ_LATENCY=3: expected responses queued at issue, checked on output.
module tb_data_memory_lsu;

  localparam int LAT   = 3;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  data_memory_lsu #(
    .XLEN(32), .ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.tag, "_rdata"}, resp_rdata, e.dat);
        check({e.tag, "_err"}, 32'(resp_err), 32'(e.err));
        check({e.tag, "_lat"}, 32'(cyc), 32'(e.cyc));
      end
    end else begin
      check("idle_rdata", resp_rdata, 32'd0);
      check("idle_err", 32'(resp_err), 32'd0);
    end
  end

  // Called #1 after a rising edge; returns #1 after the accept edge.
  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_dat,
                      input string tag, input bit expect_resp);
    exp_t e;
    check({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    if (expect_resp) begin
      e.err = exp_err;
      e.dat = exp_dat;
      e.cyc = cyc + LAT;
      e.tag = tag;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // word store then load
    send(1, 2'b10, 0, 32'h10, 32'h12345678, 0, 32'h0,        "sw10",   1);
    send(0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h12345678, "lw10",   1);
    // byte/half sub-word loads and sign handling
    send(0, 2'b00, 0, 32'h10, 32'h0,        0, 32'h00000078, "lb10",   1);
    send(0, 2'b00, 0, 32'h13, 32'h0,        0, 32'h00000012, "lb13",   1);
    send(1, 2'b00, 0, 32'h11, 32'hFFFFFF80, 0, 32'h0,        "sb11",   1);
    send(0, 2'b00, 0, 32'h11, 32'h0,        0, 32'hFFFFFF80, "lb11",   1);
    send(0, 2'b00, 1, 32'h11, 32'h0,        0, 32'h00000080, "lbu11",  1);
    send(0, 2'b01, 0, 32'h12, 32'h0,        0, 32'h00001234, "lh12",   1);
    send(0, 2'b10, 1, 32'h10, 32'h0,        0, 32'h12348078, "lw10b",  1);
    send(1, 2'b01, 0, 32'h20, 32'h1234BEEF, 0, 32'h0,        "sh20",   1);
    send(0, 2'b10, 0, 32'h20, 32'h0,        0, 32'h0000BEEF, "lw20",   1);
    send(0, 2'b01, 0, 32'h20, 32'h0,        0, 32'hFFFFBEEF, "lh20",   1);
    send(0, 2'b01, 1, 32'h20, 32'h0,        0, 32'h0000BEEF, "lhu20",  1);
    // errors and boundaries
    send(0, 2'b10, 0, 32'h22, 32'h0,        1, 32'h0,        "lw22",   1);
    send(1, 2'b10, 0, 32'h21, 32'hDEADBEEF, 1, 32'h0,        "sw21",   1);
    send(0, 2'b10, 0, 32'h20, 32'h0,        0, 32'h0000BEEF, "lw20b",  1);
    send(0, 2'b01, 0, 32'h21, 32'h0,        1, 32'h0,        "lh21",   1);
    send(0, 2'b11, 0, 32'h10, 32'h0,        1, 32'h0,        "size11", 1);
    send(0, 2'b00, 0, DEPTH,  32'h0,        1, 32'h0,        "lbtop",  1);
    send(0, 2'b10, 0, DEPTH-2,32'h0,        1, 32'h0,        "lwtop2", 1);
    send(0, 2'b00, 0, DEPTH-1,32'h0,        0, 32'h0,        "lblast", 1);
    send(0, 2'b10, 0, DEPTH-4,32'h0,        0, 32'h0,        "lwlast", 1);
    send(1, 2'b00, 0, 32'h10010, 32'h55,    1, 32'h0,        "sbhigh", 1);
    send(0, 2'b00, 0, 32'h10, 32'h0,        0, 32'h00000078, "lb10c",  1);
    drain();

    // back-to-back store/load/store/load
    send(1, 2'b10, 0, 32'h40, 32'hAAAA5555, 0, 32'h0,        "b2b_sw1", 1);
    send(0, 2'b10, 0, 32'h40, 32'h0,        0, 32'hAAAA5555, "b2b_lw1", 1);
    send(1, 2'b10, 0, 32'h40, 32'h0,        0, 32'h0,        "b2b_sw2", 1);
    send(0, 2'b10, 0, 32'h40, 32'h0,        0, 32'h0,        "b2b_lw2", 1);
    drain();

    // reset with a load in flight; the earlier store must persist
    send(1, 2'b10, 0, 32'h80, 32'hCAFEF00D, 0, 32'h0,        "sw80",   1);
    drain();
    send(0, 2'b10, 0, 32'h80, 32'h0,        0, 32'h0,        "lwdrop", 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_ready", 32'(req_ready), 32'd0);
    repeat (LAT + 3) begin
      @(posedge clk); #1;
    end
    send(0, 2'b10, 0, 32'h80, 32'h0,        0, 32'hCAFEF00D, "lw80",   1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
Byte-addressed, little-endian RISC-V data memory with a load/store front end. It supersedes the fixed 8-bit DATA_MEMORY. It takes one load or store request per cycle through a valid/ready handshake and supports byte, half and word sizes with sign or zero extension. It flags misaligned and out-of-range accesses, and returns each result after a parametrised read latency. It sits between the core's MEM stage and the backing store.

Parameters:
XLEN, 32, data path width in bits; only 32 is supported.
ADDR_WIDTH, 32, width of req_addr.
DEPTH_BYTES, 1024, memory size in bytes; must be a power of two and at least 4.
READ_LATENCY, 1, number of cycles from request accept to resp_valid; legal range 1..4.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  block can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_size  input  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
req_unsigned  input  1  loads only: 1 = zero-extend (LBU/LHU), 0 = sign-extend.
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  XLEN  store data, right-aligned (only the low bytes are used for byte/half).
resp_valid  output  1  response present for exactly one cycle.
resp_rdata  output  XLEN  extended load data; 0 for stores and on errors.
resp_err  output  1  access was misaligned, out of range, or had an illegal size.

Behaviour:
- Reset (rst=1 at an edge):
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - All pipeline stages are invalidated.
  - Memory array contents are not altered by rst. The array is zero at time 0.
  - req_ready rises at the first edge where rst=0.
- Accept:
  - A request is accepted on an edge where req_valid & req_ready.
  - req_ready stays 1 after reset; there is no response backpressure.
  - Back-to-back requests are accepted every cycle.
- Error check at accept:
  - Error when req_size=11.
  - Error when req_size=01 and addr[0]!=0.
  - Error when req_size=10 and addr[1:0]!=0.
  - Error when the access's last byte address is >= DEPTH_BYTES.
  - An erroring store writes nothing.
  - An erroring request still produces a response with resp_err=1 and resp_rdata=0.
- Store:
  - Bytes are written at the accept edge, little-endian: req_wdata[7:0] goes to addr, [15:8] to addr+1, and so on.
  - Byte stores write 1 byte, half stores 2, word stores 4.
  - The response has resp_err=0 and resp_rdata=0.
- Load:
  - Bytes are sampled at the accept edge and see every store accepted on earlier edges.
  - A store accepted later does not change an in-flight load.
  - Byte/half results are sign- or zero-extended to XLEN per req_unsigned.
  - Word loads ignore req_unsigned.
- Latency:
  - The response for a request accepted at edge N is presented with resp_valid=1 after edge N+READ_LATENCY-1, i.e. READ_LATENCY cycles after the request cycle.
  - Responses come back in order, one per accepted request.
  - Outputs are registered; resp_rdata and resp_err are 0 whenever resp_valid=0.
- Pipeline:
  - A shift chain of READ_LATENCY stages, each holding valid, err and data.
  - There is no combinational path from req_* to resp_*.
- Reset mid-operation: in-flight responses are dropped and never emitted. Stores already accepted stay committed.
- Address bits above log2(DEPTH_BYTES) only take part in the range check.

Test Plan:
- Reset, then store word 0x12345678 @0x10, then load word @0x10 -> resp_valid exactly READ_LATENCY cycles after accept, resp_rdata=0x12345678, resp_err=0.
- With word 0x12345678 @0x10: LB @0x10 -> 0x00000078. LB @0x13 -> 0x00000012. Store byte 0x80 @0x11, then LB @0x11 -> 0xFFFFFF80 and LBU @0x11 -> 0x00000080. LH @0x12 -> 0x00001234.
- SH 0xBEEF @0x20 over prior word 0 -> LW @0x20 = 0x0000BEEF. LH @0x20 -> 0xFFFFBEEF. LHU @0x20 -> 0x0000BEEF.
- Misaligned and out-of-range:
  - LW @0x22 -> resp_err=1, rdata=0.
  - SW 0xDEADBEEF @0x21 -> resp_err=1, after which LW @0x20 is still 0x0000BEEF.
  - LB @DEPTH_BYTES -> err. LW @DEPTH_BYTES-2 -> err.
- Back-to-back SW 0xAAAA5555 @0x40, LW @0x40, SW 0 @0x40, LW @0x40 in consecutive cycles (READ_LATENCY=3) -> four in-order responses; loads return 0xAAAA5555 then 0x00000000.
- Issue a load, assert rst for 1 cycle before its response -> no resp_valid emitted, req_ready=0 during reset. A store accepted before rst persists when read afterwards.
